// File: rtl/eu_pkg.sv
// Shared definitions for the execute stage: opcode encodings, FSM states
// and the control-flag portion of the result bundle.
package eu_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_XOR   = 4'h5;
    localparam logic [3:0] OP_NOT   = 4'h6;
    localparam logic [3:0] OP_SHL   = 4'h7;
    localparam logic [3:0] OP_SHR   = 4'h8;
    localparam logic [3:0] OP_MUL   = 4'hD;
    localparam logic [3:0] OP_LOAD  = 4'hE;
    localparam logic [3:0] OP_STORE = 4'hF;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } eu_state_t;

    typedef struct packed {
        logic reg_we;
        logic mem_we;
    } eu_ctrl_t;

endpackage

// File: rtl/eu_mul.sv
// Iterative shift-add multiplier: one partial product per clock, DATA_W steps,
// keeps only the low DATA_W bits of the product.
module eu_mul #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_done,
    output logic [DATA_W-1:0] o_product
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic [DATA_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_count;
    logic              r_busy;
    logic [DATA_W-1:0] w_acc_next;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    // Done is raised during the final step so the caller can capture the
    // product on the same edge that completes it.
    assign o_done     = r_busy && (r_count == LAST);
    assign o_product  = w_acc_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
        end else if (i_abort) begin
            r_count  <= '0;
            r_busy   <= 1'b0;
        end else if (i_start) begin
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (o_done) begin
                r_count <= '0;
                r_busy  <= 1'b0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/eu_pipe.sv
// Execute stage with valid/ready handshakes on both sides, synchronous flush
// and a multi-cycle multiply that stalls the input while it iterates.
module eu_pipe
    import eu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int REG_AW = 3,
    parameter int MEM_AW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_opcode,
    input  logic [REG_AW-1:0] in_a_addr,
    input  logic [REG_AW-1:0] in_b_addr,
    input  logic [REG_AW-1:0] in_dest,
    input  logic [MEM_AW-1:0] in_mem_addr,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_opcode,
    output logic [REG_AW-1:0] out_a_addr,
    output logic [REG_AW-1:0] out_dest,
    output logic [DATA_W-1:0] out_result,
    output logic              out_reg_we,
    output logic              out_mem_we,
    output logic [MEM_AW-1:0] out_mem_addr,
    output logic [DATA_W-1:0] out_store_data,
    output logic              out_zero
);

    localparam int SH_W = $clog2(DATA_W);

    typedef struct packed {
        logic [3:0]        opcode;
        logic [REG_AW-1:0] a_addr;
        logic [REG_AW-1:0] dest;
        logic [DATA_W-1:0] result;
        eu_ctrl_t          ctrl;
        logic [MEM_AW-1:0] mem_addr;
        logic [DATA_W-1:0] store_data;
    } eu_bundle_t;

    eu_state_t         r_state;
    eu_state_t         w_state_next;
    eu_bundle_t        r_out;
    logic              r_out_valid;
    logic [REG_AW-1:0] r_mul_a_addr;
    logic [REG_AW-1:0] r_mul_dest;
    eu_bundle_t        w_in_bundle;
    eu_bundle_t        w_mul_bundle;
    logic [DATA_W-1:0] w_alu;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_consume;
    logic              w_mul_start;
    logic              w_mul_done;
    logic [DATA_W-1:0] w_mul_product;

    assign w_in_ready  = (r_state == IDLE) && (!r_out_valid || out_ready) && !flush;
    assign w_accept    = in_valid && w_in_ready;
    assign w_consume   = r_out_valid && out_ready;
    assign w_mul_start = w_accept && (in_opcode == OP_MUL);

    always_comb begin
        w_alu = '0;
        case (in_opcode)
            OP_ADD:  w_alu = in_a + in_b;
            OP_SUB:  w_alu = in_a - in_b;
            OP_AND:  w_alu = in_a & in_b;
            OP_OR:   w_alu = in_a | in_b;
            OP_XOR:  w_alu = in_a ^ in_b;
            OP_NOT:  w_alu = ~in_a;
            OP_SHL:  w_alu = in_a << in_b[SH_W-1:0];
            OP_SHR:  w_alu = in_a >> in_b[SH_W-1:0];
            default: w_alu = '0;
        endcase
    end

    always_comb begin
        w_in_bundle             = '0;
        w_in_bundle.opcode      = in_opcode;
        w_in_bundle.a_addr      = in_a_addr;
        w_in_bundle.dest        = in_dest;
        w_in_bundle.ctrl.reg_we = 1'b1;
        case (in_opcode)
            OP_LOAD: begin
                w_in_bundle.mem_addr = in_mem_addr;
            end
            OP_STORE: begin
                w_in_bundle.ctrl.reg_we = 1'b0;
                w_in_bundle.ctrl.mem_we = 1'b1;
                w_in_bundle.mem_addr    = in_mem_addr;
                w_in_bundle.store_data  = in_a;
            end
            default: begin
                w_in_bundle.result = w_alu;
            end
        endcase
    end

    always_comb begin
        w_mul_bundle             = '0;
        w_mul_bundle.opcode      = OP_MUL;
        w_mul_bundle.a_addr      = r_mul_a_addr;
        w_mul_bundle.dest        = r_mul_dest;
        w_mul_bundle.result      = w_mul_product;
        w_mul_bundle.ctrl.reg_we = 1'b1;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_mul_start) w_state_next = BUSY;
            BUSY:    if (flush || w_mul_done) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Flush wins over everything; a NOP or MUL accepted while a bundle is
    // consumed leaves out_valid low because nothing new is produced yet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out        <= '0;
            r_out_valid  <= 1'b0;
            r_mul_a_addr <= '0;
            r_mul_dest   <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (r_state == BUSY) begin
            if (w_mul_done) begin
                r_out       <= w_mul_bundle;
                r_out_valid <= 1'b1;
            end
        end else if (w_accept) begin
            case (in_opcode)
                OP_NOP: begin
                    r_out_valid <= 1'b0;
                end
                OP_MUL: begin
                    r_out_valid  <= 1'b0;
                    r_mul_a_addr <= in_a_addr;
                    r_mul_dest   <= in_dest;
                end
                default: begin
                    r_out       <= w_in_bundle;
                    r_out_valid <= 1'b1;
                end
            endcase
        end else if (w_consume) begin
            r_out_valid <= 1'b0;
        end
    end

    eu_mul #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_mul_start),
        .i_abort   (flush),
        .i_a       (in_a),
        .i_b       (in_b),
        .o_done    (w_mul_done),
        .o_product (w_mul_product)
    );

    assign in_ready       = w_in_ready;
    assign out_valid      = r_out_valid;
    assign out_opcode     = r_out.opcode;
    assign out_a_addr     = r_out.a_addr;
    assign out_dest       = r_out.dest;
    assign out_result     = r_out.result;
    assign out_reg_we     = r_out.ctrl.reg_we;
    assign out_mem_we     = r_out.ctrl.mem_we;
    assign out_mem_addr   = r_out.mem_addr;
    assign out_store_data = r_out.store_data;
    assign out_zero       = (r_out.result == '0);

endmodule

// File: tb/tb_eu_pipe.sv
// Randomised and directed bench for eu_pipe, checked against a transaction-level
// model of the stage (held bundle, multiply countdown, flush).
module tb_eu_pipe;

    localparam int DW = 8;
    localparam int RW = 3;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_opcode = '0;
    logic [RW-1:0] in_a_addr = '0;
    logic [RW-1:0] in_b_addr = '0;
    logic [RW-1:0] in_dest = '0;
    logic [MW-1:0] in_mem_addr = '0;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [3:0]    out_opcode;
    logic [RW-1:0] out_a_addr;
    logic [RW-1:0] out_dest;
    logic [DW-1:0] out_result;
    logic          out_reg_we;
    logic          out_mem_we;
    logic [MW-1:0] out_mem_addr;
    logic [DW-1:0] out_store_data;
    logic          out_zero;

    eu_pipe #(.DATA_W(DW), .REG_AW(RW), .MEM_AW(MW)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_opcode      (in_opcode),
        .in_a_addr      (in_a_addr),
        .in_b_addr      (in_b_addr),
        .in_dest        (in_dest),
        .in_mem_addr    (in_mem_addr),
        .in_a           (in_a),
        .in_b           (in_b),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_opcode     (out_opcode),
        .out_a_addr     (out_a_addr),
        .out_dest       (out_dest),
        .out_result     (out_result),
        .out_reg_we     (out_reg_we),
        .out_mem_we     (out_mem_we),
        .out_mem_addr   (out_mem_addr),
        .out_store_data (out_store_data),
        .out_zero       (out_zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]    op;
        logic [RW-1:0] aa;
        logic [RW-1:0] dest;
        logic [DW-1:0] res;
        logic          rwe;
        logic          mwe;
        logic [MW-1:0] maddr;
        logic [DW-1:0] sdata;
    } exp_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   n_xfer = 0;
    logic m_valid = 1'b0;
    int   m_busy = 0;
    exp_t m_exp = '0;
    exp_t m_pend = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference result of one instruction from the opcode table.
    function automatic exp_t predict(input logic [3:0] op, input logic [DW-1:0] a,
                                     input logic [DW-1:0] b, input logic [RW-1:0] aa,
                                     input logic [RW-1:0] dest, input logic [MW-1:0] maddr);
        exp_t e;
        logic [2*DW-1:0] prod;
        e = '0;
        e.op = op;
        e.aa = aa;
        e.dest = dest;
        e.rwe = 1'b1;
        prod = a * b;
        case (op)
            4'd1:  e.res = a + b;
            4'd2:  e.res = a - b;
            4'd3:  e.res = a & b;
            4'd4:  e.res = a | b;
            4'd5:  e.res = a ^ b;
            4'd6:  e.res = ~a;
            4'd7:  e.res = a << (b % DW);
            4'd8:  e.res = a >> (b % DW);
            4'd13: e.res = prod[DW-1:0];
            4'd14: e.maddr = maddr;
            4'd15: begin
                e.rwe = 1'b0;
                e.mwe = 1'b1;
                e.maddr = maddr;
                e.sdata = a;
            end
            default: e.res = '0;
        endcase
        return e;
    endfunction

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            chk("out_opcode", 32'(out_opcode), 32'(m_exp.op));
            chk("out_a_addr", 32'(out_a_addr), 32'(m_exp.aa));
            chk("out_dest", 32'(out_dest), 32'(m_exp.dest));
            chk("out_result", 32'(out_result), 32'(m_exp.res));
            chk("out_reg_we", 32'(out_reg_we), 32'(m_exp.rwe));
            chk("out_mem_we", 32'(out_mem_we), 32'(m_exp.mwe));
            chk("out_mem_addr", 32'(out_mem_addr), 32'(m_exp.maddr));
            chk("out_store_data", 32'(out_store_data), 32'(m_exp.sdata));
            chk("out_zero", 32'(out_zero), 32'(m_exp.res == '0));
        end
    endtask

    // One clock of stimulus: drive, check in_ready, advance model, check outputs.
    task automatic step(input logic v, input logic [3:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [RW-1:0] dest,
                        input logic [MW-1:0] maddr, input logic ordy, input logic fl);
        logic exp_rdy;
        in_valid = v;
        in_opcode = op;
        in_a = a;
        in_b = b;
        in_dest = dest;
        in_mem_addr = maddr;
        in_a_addr = RW'($urandom);
        in_b_addr = RW'($urandom);
        out_ready = ordy;
        flush = fl;
        #1;
        exp_rdy = (m_busy == 0) && (!m_valid || ordy) && !fl;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (out_valid && out_ready) n_xfer++;
        if (fl) begin
            m_valid = 1'b0;
            m_busy = 0;
        end else if (m_busy != 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_valid = 1'b1;
                m_exp = m_pend;
            end
        end else begin
            if (m_valid && ordy) m_valid = 1'b0;
            if (v && exp_rdy) begin
                if (op == 4'd13) begin
                    m_busy = DW;
                    m_pend = predict(op, a, b, in_a_addr, dest, maddr);
                end else if (op != 4'd0) begin
                    m_valid = 1'b1;
                    m_exp = predict(op, a, b, in_a_addr, dest, maddr);
                end
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, '0, '0, '0, '0, ordy, 1'b0);
    endtask

    // Asserts reset between edges and checks that outputs clear without a clock.
    task automatic apply_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", 32'(out_result), 32'd0);
        chk("rst_out_reg_we", 32'(out_reg_we), 32'd0);
        chk("rst_out_mem_we", 32'(out_mem_we), 32'd0);
        chk("rst_out_opcode", 32'(out_opcode), 32'd0);
        chk("rst_out_dest", 32'(out_dest), 32'd0);
        chk("rst_out_a_addr", 32'(out_a_addr), 32'd0);
        chk("rst_out_mem_addr", 32'(out_mem_addr), 32'd0);
        chk("rst_out_store_data", 32'(out_store_data), 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd1);
        m_valid = 1'b0;
        m_busy = 0;
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int x0;
        #3;
        apply_reset();

        step(1'b1, 4'd1, 8'h7F, 8'h01, 3'd3, 4'h0, 1'b1, 1'b0);
        chk("add_result", 32'(out_result), 32'h80);
        chk("add_dest", 32'(out_dest), 32'd3);

        step(1'b1, 4'd15, 8'h55, 8'h00, 3'd1, 4'hA, 1'b1, 1'b0);
        chk("store_data", 32'(out_store_data), 32'h55);
        chk("store_addr", 32'(out_mem_addr), 32'hA);
        idle(1, 1'b1);

        step(1'b1, 4'd13, 8'd13, 8'd11, 3'd5, 4'h0, 1'b1, 1'b0);
        idle(DW, 1'b1);
        chk("mul_result", 32'(out_result), 32'h8F);
        idle(1, 1'b1);

        step(1'b1, 4'd2, 8'h00, 8'h01, 3'd2, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 4'd5, 8'hF0, 8'h3C, 3'd4, 4'h0, 1'b0, 1'b0);
        chk("sub_held", 32'(out_result), 32'hFF);
        step(1'b1, 4'd5, 8'hF0, 8'h3C, 3'd4, 4'h0, 1'b1, 1'b0);
        chk("xor_result", 32'(out_result), 32'hCC);
        idle(1, 1'b1);

        step(1'b1, 4'd13, 8'd200, 8'd7, 3'd6, 4'h0, 1'b1, 1'b0);
        idle(3, 1'b1);
        step(1'b0, 4'd0, '0, '0, '0, '0, 1'b1, 1'b1);
        idle(DW + 2, 1'b1);

        x0 = n_xfer;
        step(1'b1, 4'd1, 8'd1, 8'd2, 3'd1, 4'h0, 1'b1, 1'b0);
        step(1'b1, 4'd0, 8'd0, 8'd0, 3'd0, 4'h0, 1'b1, 1'b0);
        step(1'b1, 4'd1, 8'd3, 8'd4, 3'd2, 4'h0, 1'b1, 1'b0);
        idle(2, 1'b1);
        chk("nop_bundles", 32'(n_xfer - x0), 32'd2);

        step(1'b1, 4'd6, 8'h0F, 8'h00, 3'd7, 4'h0, 1'b0, 1'b0);
        apply_reset();

        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), DW'($urandom),
                 DW'($urandom), RW'($urandom), MW'($urandom),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
            if (i == 700) apply_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
